// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU take WIDTH cycles; MTHI/MTLO complete in one edge.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_div_zero;
  // Datapath: MUL keeps {partial, multiplier}; DIV keeps {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_a_orig;
  logic               r_neg, r_rem_neg, r_b_zero;

  logic               w_signed, w_a_neg, w_b_neg, w_accept, w_last;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_sum, w_shift, w_diff;
  logic [2*WIDTH-1:0] w_mul_nxt, w_div_nxt, w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;

  assign w_signed = (op == OP_MULT) || (op == OP_DIV);
  assign w_a_neg  = w_signed && a[WIDTH-1];
  assign w_b_neg  = w_signed && b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;
  assign w_accept = (r_state == S_IDLE) && start && (op <= OP_DIVU);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // Shift-add step: add multiplicand into the upper half when the current multiplier bit is set.
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

  // Restoring step: a borrow out of the top bit means the trial subtraction is discarded.
  assign w_shift   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff    = w_shift - {1'b0, r_opnd};
  assign w_div_nxt = w_diff[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                   : {w_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

  assign w_prod = r_neg     ? -w_mul_nxt : w_mul_nxt;
  assign w_quo  = r_neg     ? -w_div_nxt[WIDTH-1:0] : w_div_nxt[WIDTH-1:0];
  assign w_rem  = r_rem_neg ? -w_div_nxt[2*WIDTH-1:WIDTH] : w_div_nxt[2*WIDTH-1:WIDTH];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin r_state <= S_MUL; r_cnt <= '0; end
              OP_DIV, OP_DIVU:   begin r_state <= S_DIV; r_cnt <= '0; end
              OP_MTHI:           r_hi <= a;
              OP_MTLO:           r_lo <= a;
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          if (cancel) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state <= S_DONE;
              if (r_state == S_MUL) begin
                {r_hi, r_lo} <= w_prod;
              end else begin
                r_div_zero <= r_b_zero;
                r_hi       <= r_b_zero ? r_a_orig : w_rem;
                r_lo       <= r_b_zero ? '1 : w_quo;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: operand/accumulator registers carry no reset; they are always loaded before being used.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_opnd    <= (op <= OP_MULTU) ? w_a_mag : w_b_mag;
      r_acc     <= (op <= OP_MULTU) ? {{WIDTH{1'b0}}, w_b_mag} : {{WIDTH{1'b0}}, w_a_mag};
      r_neg     <= w_a_neg ^ w_b_neg;
      r_rem_neg <= w_a_neg;
      r_a_orig  <= a;
      r_b_zero  <= (b == '0);
    end else if (r_state == S_MUL) begin
      r_acc <= w_mul_nxt;
    end else if (r_state == S_DIV) begin
      r_acc <= w_div_nxt;
    end
  end

  assign busy     = (r_state == S_MUL) || (r_state == S_DIV);
  assign done     = (r_state == S_DONE);
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_mul_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn, start, cancel;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  mul_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int unsigned  cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetn === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", {63'd0, done}, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("result_hi", {32'd0, hi}, {32'd0, mon_e.hi});
        check("result_lo", {32'd0, lo}, {32'd0, mon_e.lo});
        check("result_div_zero", {63'd0, div_zero}, {63'd0, mon_e.dz});
        check("done_latency", {32'd0, cyc}, {32'd0, mon_e.cyc});
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit expect_done, input logic [W-1:0] eh, input logic [W-1:0] el,
                       input logic edz);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    if (expect_done) begin
      e.hi = eh; e.lo = el; e.dz = edz; e.cyc = cyc + 1 + W;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic move_to(input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] eh, input logic [W-1:0] el);
    @(negedge clk);
    start = 1'b1; op = o; a = x;
    @(negedge clk);
    start = 1'b0;
    check("mt_hi", {32'd0, hi}, {32'd0, eh});
    check("mt_lo", {32'd0, lo}, {32'd0, el});
    check("mt_no_done", {63'd0, done}, 64'd0);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", {63'd0, (n < 200)}, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int nb;
    resetn = 1'b0; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_div_zero", {63'd0, div_zero}, 64'd0);
    resetn = 1'b1;

    // MULT -3 * 5, plus busy width.
    issue(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    nb = 0;
    while (busy && nb < 100) begin
      nb++;
      @(negedge clk);
    end
    check("mult_busy_cycles", 64'(nb), 64'd32);
    drain();

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    drain();
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    drain();
    issue(3'd3, 32'd7, 32'd0, 1'b1, 32'd7, 32'hFFFF_FFFF, 1'b1);
    drain();
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0);
    drain();
    issue(3'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1, 32'd0, 32'd6, 1'b0);
    drain();
    issue(3'd3, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
    drain();

    // MTHI then MTLO, each visible right after its edge.
    move_to(3'd4, 32'h1234_5678, 32'h1234_5678, 32'd14);
    move_to(3'd5, 32'h9ABC_DEF0, 32'h1234_5678, 32'h9ABC_DEF0);

    // MTHI while busy must be ignored.
    issue(3'd0, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12, 1'b0);
    start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    check("busy_mthi_hi", {32'd0, hi}, {32'd0, 32'h1234_5678});
    check("busy_mthi_busy", {63'd0, busy}, 64'd1);
    drain();

    // Cancel mid-multiply; a same-cycle MTHI is ignored too.
    move_to(3'd4, 32'hAAAA_5555, 32'hAAAA_5555, 32'd12);
    move_to(3'd5, 32'h5555_AAAA, 32'hAAAA_5555, 32'h5555_AAAA);
    issue(3'd0, 32'd3, 32'd4, 1'b0, '0, '0, 1'b0);
    repeat (9) @(negedge clk);
    cancel = 1'b1; start = 1'b1; op = 3'd4; a = 32'h1111_1111;
    @(negedge clk);
    cancel = 1'b0; start = 1'b0;
    check("cancel_busy", {63'd0, busy}, 64'd0);
    check("cancel_hi", {32'd0, hi}, {32'd0, 32'hAAAA_5555});
    check("cancel_lo", {32'd0, lo}, {32'd0, 32'h5555_AAAA});
    repeat (40) @(negedge clk);
    check("cancel_hi_later", {32'd0, hi}, {32'd0, 32'hAAAA_5555});

    // Set div_zero so reset has something to clear.
    issue(3'd3, 32'd5, 32'd0, 1'b1, 32'd5, 32'hFFFF_FFFF, 1'b1);
    drain();

    // Reset in the middle of a divide.
    issue(3'd3, 32'd100, 32'd7, 1'b0, '0, '0, 1'b0);
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("midreset_hi", {32'd0, hi}, 64'd0);
    check("midreset_lo", {32'd0, lo}, 64'd0);
    check("midreset_busy", {63'd0, busy}, 64'd0);
    check("midreset_div_zero", {63'd0, div_zero}, 64'd0);
    repeat (40) @(negedge clk);
    issue(3'd3, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
    drain();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised iterative multiply/divide unit owning the architectural HI/LO registers; successor to the single-cycle ALU HI/LO path.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles, and MTHI/MTLO in a single cycle.
- Sits beside the EX-stage ALU. Provides a busy/stall signal to the pipeline and HI/LO read values for MFHI/MFLO.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  synchronous active-low reset, sampled on rising edge of clk.
- start  in  1  request strobe; op/a/b are sampled in the same cycle.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=reserved (ignored).
- a  in  WIDTH  multiplicand/dividend; source for MTHI/MTLO.
- b  in  WIDTH  multiplier/divisor.
- cancel  in  1  exception flush; aborts any in-flight operation.
- busy  out  1  high while a MUL/DIV is iterating; the pipeline stalls on it.
- done  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- div_zero  out  1  sticky flag for the last DIV/DIVU; set when the divisor was 0, cleared by the next accepted DIV/DIVU.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (resetn=0 at an edge): state=IDLE; hi, lo, busy, done, div_zero and the counter all go to 0.
  - Reset has priority over cancel and start.
  - Reset mid-operation discards the operation; no done pulse is issued.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start & op in {0,1}: latch operands, counter=0, go to MUL.
  - start & op in {2,3}: latch operands, counter=0, go to DIV.
  - start & op=4: hi<=a at the edge. start & op=5: lo<=a at the edge. State stays IDLE, no done pulse.
  - start with op 6/7: ignored.
- Signed ops (MULT, DIV):
  - Operands are converted to magnitudes on entry. Signs are stored.
  - Result is sign-corrected at completion: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
- MUL: shift-add, one multiplier bit per cycle, 2*WIDTH accumulator.
- DIV: restoring, one quotient bit per cycle.
- Counter increments every cycle in MUL/DIV. After the WIDTH-th iteration edge, the final result is written and the state moves to DONE:
  - MUL: {hi,lo} <= product.
  - DIV: lo <= quotient, hi <= remainder.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. A start in DONE is ignored; upstream retries in IDLE.
- Latency: a start sampled at edge E0 gives done high in the cycle after edge E0+WIDTH.
- busy is 1 exactly in MUL and DIV states (registered; WIDTH cycles).
- start while busy is ignored, including MTHI/MTLO. hi/lo are unchanged.
- cancel=1 in MUL/DIV: next state is IDLE. hi/lo are untouched, no done pulse, div_zero keeps its prior value. cancel in IDLE/DONE has no effect; a start in the same cycle as cancel is ignored.
- Divide by zero: result hi=a (original dividend), lo=all ones. div_zero=1. Full WIDTH-cycle latency is kept.
- Signed overflow (-2^(WIDTH-1) / -1): lo=0x8000_0000, hi=0 at WIDTH=32. No trap.
- hi/lo change only on reset, MTHI/MTLO, or MUL/DIV completion.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> done 33 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for exactly 32 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU a=7, b=0 -> hi=7, lo=0xFFFFFFFF, div_zero=1. Then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 -> hi/lo updated at their respective edges. A later MTHI issued while busy leaves hi unchanged.
- Start MULT 3*4, assert cancel at iteration 10 -> no done pulse, hi/lo keep the prior values, busy=0 next cycle.
- Start DIVU 100/7, drive resetn=0 at iteration 5 -> hi=lo=0, done never pulses. A new DIVU 100/7 then yields lo=14, hi=2.
